// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg: shared widths, FSM state codes and index-width helper for axi_rw_arbiter.
package axi_arb_pkg;
  localparam int ID_W    = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int STRB_W  = 4;
  localparam int LEN_W   = 4;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int LOCK_W  = 2;
  localparam int CACHE_W = 4;
  localparam int PROT_W  = 3;
  localparam int RESP_W  = 2;
  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_ADDR = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_XFER = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/axi_rw_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, first set request at or after ptr_i, cyclic.
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] gnt_o,
  output logic          any_o
);
  // Second pass overrides the wrap-around choice with the lowest index at or after ptr_i.
  always_comb begin
    gnt_o = '0;
    for (int i = N - 1; i >= 0; i--) if (req_i[i]) gnt_o = IW'(i);
    for (int i = N - 1; i >= 0; i--) if (req_i[i] && i >= int'(ptr_i)) gnt_o = IW'(i);
  end
  assign any_o = |req_i;
endmodule

// File: rtl/axi_rw_arbiter.sv
// axi_rw_arbiter: shares one AXI3 master port among N_REQ requesters with independent round-robin read/write arbiters.
module axi_rw_arbiter
  import axi_arb_pkg::*;
#(
  parameter int N_REQ = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ*ID_W-1:0]    s_arid,
  input  logic [N_REQ*ADDR_W-1:0]  s_araddr,
  input  logic [N_REQ*LEN_W-1:0]   s_arlen,
  input  logic [N_REQ*SIZE_W-1:0]  s_arsize,
  input  logic [N_REQ*BURST_W-1:0] s_arburst,
  input  logic [N_REQ*LOCK_W-1:0]  s_arlock,
  input  logic [N_REQ*CACHE_W-1:0] s_arcache,
  input  logic [N_REQ*PROT_W-1:0]  s_arprot,
  input  logic [N_REQ-1:0]         s_arvalid,
  output logic [N_REQ-1:0]         s_arready,
  output logic [N_REQ*ID_W-1:0]    s_rid,
  output logic [N_REQ*DATA_W-1:0]  s_rdata,
  output logic [N_REQ*RESP_W-1:0]  s_rresp,
  output logic [N_REQ-1:0]         s_rlast,
  output logic [N_REQ-1:0]         s_rvalid,
  input  logic [N_REQ-1:0]         s_rready,
  input  logic [N_REQ*ID_W-1:0]    s_awid,
  input  logic [N_REQ*ADDR_W-1:0]  s_awaddr,
  input  logic [N_REQ*LEN_W-1:0]   s_awlen,
  input  logic [N_REQ*SIZE_W-1:0]  s_awsize,
  input  logic [N_REQ*BURST_W-1:0] s_awburst,
  input  logic [N_REQ*LOCK_W-1:0]  s_awlock,
  input  logic [N_REQ*CACHE_W-1:0] s_awcache,
  input  logic [N_REQ*PROT_W-1:0]  s_awprot,
  input  logic [N_REQ-1:0]         s_awvalid,
  output logic [N_REQ-1:0]         s_awready,
  input  logic [N_REQ*ID_W-1:0]    s_wid,
  input  logic [N_REQ*DATA_W-1:0]  s_wdata,
  input  logic [N_REQ*STRB_W-1:0]  s_wstrb,
  input  logic [N_REQ-1:0]         s_wlast,
  input  logic [N_REQ-1:0]         s_wvalid,
  output logic [N_REQ-1:0]         s_wready,
  output logic [N_REQ*ID_W-1:0]    s_bid,
  output logic [N_REQ*RESP_W-1:0]  s_bresp,
  output logic [N_REQ-1:0]         s_bvalid,
  input  logic [N_REQ-1:0]         s_bready,
  output logic [ID_W-1:0]          m_arid,
  output logic [ADDR_W-1:0]        m_araddr,
  output logic [LEN_W-1:0]         m_arlen,
  output logic [SIZE_W-1:0]        m_arsize,
  output logic [BURST_W-1:0]       m_arburst,
  output logic [LOCK_W-1:0]        m_arlock,
  output logic [CACHE_W-1:0]       m_arcache,
  output logic [PROT_W-1:0]        m_arprot,
  output logic                     m_arvalid,
  input  logic                     m_arready,
  input  logic [ID_W-1:0]          m_rid,
  input  logic [DATA_W-1:0]        m_rdata,
  input  logic [RESP_W-1:0]        m_rresp,
  input  logic                     m_rlast,
  input  logic                     m_rvalid,
  output logic                     m_rready,
  output logic [ID_W-1:0]          m_awid,
  output logic [ADDR_W-1:0]        m_awaddr,
  output logic [LEN_W-1:0]         m_awlen,
  output logic [SIZE_W-1:0]        m_awsize,
  output logic [BURST_W-1:0]       m_awburst,
  output logic [LOCK_W-1:0]        m_awlock,
  output logic [CACHE_W-1:0]       m_awcache,
  output logic [PROT_W-1:0]        m_awprot,
  output logic                     m_awvalid,
  input  logic                     m_awready,
  output logic [ID_W-1:0]          m_wid,
  output logic [DATA_W-1:0]        m_wdata,
  output logic [STRB_W-1:0]        m_wstrb,
  output logic                     m_wlast,
  output logic                     m_wvalid,
  input  logic                     m_wready,
  input  logic [ID_W-1:0]          m_bid,
  input  logic [RESP_W-1:0]        m_bresp,
  input  logic                     m_bvalid,
  output logic                     m_bready
);
  localparam int IW = idx_w(N_REQ);
  logic [1:0] r_state_q, r_state_d, w_state_q, w_state_d;
  logic [IW-1:0] rgnt_q, rgnt_d, rptr_q, rptr_d, wgnt_q, wgnt_d, wptr_q, wptr_d, r_pick, w_pick;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d, r_any, w_any;
  logic ra, rd, wx, wr, aw_hs, wl_hs;
  logic [N_REQ-1:0] rsel, wsel;
  rr_pick #(.N(N_REQ), .IW(IW)) u_rpick (.req_i(s_arvalid), .ptr_i(rptr_q), .gnt_o(r_pick), .any_o(r_any));
  // A requester may present W beats before AW, so either channel can win the write grant.
  rr_pick #(.N(N_REQ), .IW(IW)) u_wpick (.req_i(s_awvalid | s_wvalid), .ptr_i(wptr_q), .gnt_o(w_pick), .any_o(w_any));
  assign ra   = r_state_q == R_ADDR;
  assign rd   = r_state_q == R_DATA;
  assign wx   = w_state_q == W_XFER;
  assign wr   = w_state_q == W_RESP;
  assign rsel = N_REQ'(1) << rgnt_q;
  assign wsel = N_REQ'(1) << wgnt_q;
  assign m_arid    = ra ? s_arid[rgnt_q*ID_W +: ID_W] : '0;
  assign m_araddr  = ra ? s_araddr[rgnt_q*ADDR_W +: ADDR_W] : '0;
  assign m_arlen   = ra ? s_arlen[rgnt_q*LEN_W +: LEN_W] : '0;
  assign m_arsize  = ra ? s_arsize[rgnt_q*SIZE_W +: SIZE_W] : '0;
  assign m_arburst = ra ? s_arburst[rgnt_q*BURST_W +: BURST_W] : '0;
  assign m_arlock  = ra ? s_arlock[rgnt_q*LOCK_W +: LOCK_W] : '0;
  assign m_arcache = ra ? s_arcache[rgnt_q*CACHE_W +: CACHE_W] : '0;
  assign m_arprot  = ra ? s_arprot[rgnt_q*PROT_W +: PROT_W] : '0;
  assign m_arvalid = ra & s_arvalid[rgnt_q];
  assign s_arready = {N_REQ{ra & m_arready}} & rsel;
  assign s_rid     = rd ? {N_REQ{m_rid}} : '0;
  assign s_rdata   = rd ? {N_REQ{m_rdata}} : '0;
  assign s_rresp   = rd ? {N_REQ{m_rresp}} : '0;
  assign s_rlast   = rd ? {N_REQ{m_rlast}} : '0;
  assign s_rvalid  = {N_REQ{rd & m_rvalid}} & rsel;
  assign m_rready  = rd & s_rready[rgnt_q];
  assign m_awid    = wx ? s_awid[wgnt_q*ID_W +: ID_W] : '0;
  assign m_awaddr  = wx ? s_awaddr[wgnt_q*ADDR_W +: ADDR_W] : '0;
  assign m_awlen   = wx ? s_awlen[wgnt_q*LEN_W +: LEN_W] : '0;
  assign m_awsize  = wx ? s_awsize[wgnt_q*SIZE_W +: SIZE_W] : '0;
  assign m_awburst = wx ? s_awburst[wgnt_q*BURST_W +: BURST_W] : '0;
  assign m_awlock  = wx ? s_awlock[wgnt_q*LOCK_W +: LOCK_W] : '0;
  assign m_awcache = wx ? s_awcache[wgnt_q*CACHE_W +: CACHE_W] : '0;
  assign m_awprot  = wx ? s_awprot[wgnt_q*PROT_W +: PROT_W] : '0;
  assign m_awvalid = wx & ~aw_done_q & s_awvalid[wgnt_q];
  assign s_awready = {N_REQ{wx & ~aw_done_q & m_awready}} & wsel;
  assign m_wid     = wx ? s_wid[wgnt_q*ID_W +: ID_W] : '0;
  assign m_wdata   = wx ? s_wdata[wgnt_q*DATA_W +: DATA_W] : '0;
  assign m_wstrb   = wx ? s_wstrb[wgnt_q*STRB_W +: STRB_W] : '0;
  assign m_wlast   = wx & s_wlast[wgnt_q];
  assign m_wvalid  = wx & ~w_done_q & s_wvalid[wgnt_q];
  assign s_wready  = {N_REQ{wx & ~w_done_q & m_wready}} & wsel;
  assign s_bid     = wr ? {N_REQ{m_bid}} : '0;
  assign s_bresp   = wr ? {N_REQ{m_bresp}} : '0;
  assign s_bvalid  = {N_REQ{wr & m_bvalid}} & wsel;
  assign m_bready  = wr & s_bready[wgnt_q];
  assign aw_hs     = m_awvalid & m_awready;
  assign wl_hs     = m_wvalid & m_wready & m_wlast;
  always_comb begin
    r_state_d = r_state_q;
    rgnt_d    = rgnt_q;
    rptr_d    = rptr_q;
    if (r_state_q == R_IDLE && r_any) begin
      r_state_d = R_ADDR;
      rgnt_d    = r_pick;
    end
    if (m_arvalid && m_arready) r_state_d = R_DATA;
    if (rd && m_rvalid && m_rready && m_rlast) begin
      r_state_d = R_IDLE;
      rptr_d    = (rgnt_q == IW'(N_REQ - 1)) ? '0 : rgnt_q + 1'b1;
    end
  end
  always_comb begin
    w_state_d = w_state_q;
    wgnt_d    = wgnt_q;
    wptr_d    = wptr_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    if (w_state_q == W_IDLE) begin
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
      if (w_any) begin
        w_state_d = W_XFER;
        wgnt_d    = w_pick;
      end
    end
    if (wx) begin
      aw_done_d = aw_done_q | aw_hs;
      w_done_d  = w_done_q | wl_hs;
      if (aw_done_d && w_done_d) w_state_d = W_RESP;
    end
    if (wr && m_bvalid && m_bready) begin
      w_state_d = W_IDLE;
      wptr_d    = (wgnt_q == IW'(N_REQ - 1)) ? '0 : wgnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      rgnt_q    <= '0;
      rptr_q    <= '0;
      w_state_q <= W_IDLE;
      wgnt_q    <= '0;
      wptr_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      rgnt_q    <= rgnt_d;
      rptr_q    <= rptr_d;
      w_state_q <= w_state_d;
      wgnt_q    <= wgnt_d;
      wptr_q    <= wptr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end
endmodule

// File: tb/tb_axi_rw_arbiter.sv
// tb_axi_rw_arbiter: directed table-driven and sequence checks for axi_rw_arbiter with three requesters.
module tb_axi_rw_arbiter;
  import axi_arb_pkg::*;
  localparam int N = 3;
  logic clk = 1'b0, rst = 1'b1;
  logic [N*ID_W-1:0] s_arid, s_rid, s_awid, s_wid, s_bid;
  logic [N*ADDR_W-1:0] s_araddr, s_awaddr;
  logic [N*LEN_W-1:0] s_arlen, s_awlen;
  logic [N*SIZE_W-1:0] s_arsize, s_awsize;
  logic [N*BURST_W-1:0] s_arburst, s_awburst;
  logic [N*LOCK_W-1:0] s_arlock, s_awlock;
  logic [N*CACHE_W-1:0] s_arcache, s_awcache;
  logic [N*PROT_W-1:0] s_arprot, s_awprot;
  logic [N*DATA_W-1:0] s_rdata, s_wdata;
  logic [N*RESP_W-1:0] s_rresp, s_bresp;
  logic [N*STRB_W-1:0] s_wstrb;
  logic [N-1:0] s_arvalid, s_arready, s_rlast, s_rvalid, s_rready, s_awvalid, s_awready;
  logic [N-1:0] s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [ID_W-1:0] m_arid, m_rid, m_awid, m_wid, m_bid;
  logic [ADDR_W-1:0] m_araddr, m_awaddr;
  logic [LEN_W-1:0] m_arlen, m_awlen;
  logic [SIZE_W-1:0] m_arsize, m_awsize;
  logic [BURST_W-1:0] m_arburst, m_awburst;
  logic [LOCK_W-1:0] m_arlock, m_awlock;
  logic [CACHE_W-1:0] m_arcache, m_awcache;
  logic [PROT_W-1:0] m_arprot, m_awprot;
  logic [DATA_W-1:0] m_rdata, m_wdata;
  logic [RESP_W-1:0] m_rresp, m_bresp;
  logic [STRB_W-1:0] m_wstrb;
  logic m_arvalid, m_arready, m_rlast, m_rvalid, m_rready, m_awvalid, m_awready;
  logic m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  axi_rw_arbiter #(.N_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arlock(s_arlock), .s_arcache(s_arcache), .s_arprot(s_arprot),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awlock(s_awlock), .s_awcache(s_awcache), .s_awprot(s_awprot),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wid(s_wid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache), .m_awprot(m_awprot),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wid(m_wid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );
  typedef struct {
    logic [2:0]  arv;
    logic        ardy;
    logic [2:0]  rrdy;
    logic        e_mav;
    logic [2:0]  e_sar;
    logic [2:0]  e_srv;
    logic        e_mrr;
    logic [31:0] e_addr;
  } rvec_t;
  rvec_t tbl[14];
  localparam logic [31:0] A0 = 32'h1000_0000, A1 = 32'h1FC0_0000, A2 = 32'h1000_0200;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic settle();
    #4;
  endtask
  function automatic logic [31:0] ctl_outs();
    return 32'({s_arready, s_rvalid, s_awready, s_wready, s_bvalid,
                m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready});
  endfunction
  task automatic clear();
    {s_arid, s_arlen, s_arsize, s_arburst, s_arlock, s_arcache, s_arprot, s_arvalid} = '0;
    {s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awlock, s_awcache, s_awprot, s_awvalid} = '0;
    {s_wid, s_wdata, s_wstrb, s_wlast, s_wvalid, s_rready, s_bready} = '0;
    {m_arready, m_rid, m_rdata, m_rresp, m_rlast, m_rvalid} = '0;
    {m_awready, m_wready, m_bid, m_bresp, m_bvalid} = '0;
    s_araddr = {A2, A1, A0};
  endtask
  task automatic do_reset();
    clear();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask
  initial begin
    int beats, bcnt, bad, mirr_err, data_err;
    tbl[0]  = '{3'b111, 1'b1, 3'b111, 1'b0, 3'b000, 3'b000, 1'b0, 32'h0};
    tbl[1]  = '{3'b111, 1'b0, 3'b111, 1'b1, 3'b000, 3'b000, 1'b0, A0};
    tbl[2]  = '{3'b111, 1'b1, 3'b111, 1'b1, 3'b001, 3'b000, 1'b0, A0};
    tbl[3]  = '{3'b111, 1'b1, 3'b110, 1'b0, 3'b000, 3'b001, 1'b0, 32'h0};
    tbl[4]  = '{3'b111, 1'b1, 3'b111, 1'b0, 3'b000, 3'b001, 1'b1, 32'h0};
    tbl[5]  = '{3'b111, 1'b1, 3'b111, 1'b0, 3'b000, 3'b000, 1'b0, 32'h0};
    tbl[6]  = '{3'b111, 1'b1, 3'b111, 1'b1, 3'b010, 3'b000, 1'b0, A1};
    tbl[7]  = '{3'b111, 1'b1, 3'b111, 1'b0, 3'b000, 3'b010, 1'b1, 32'h0};
    tbl[8]  = '{3'b101, 1'b1, 3'b111, 1'b0, 3'b000, 3'b000, 1'b0, 32'h0};
    tbl[9]  = '{3'b101, 1'b1, 3'b111, 1'b1, 3'b100, 3'b000, 1'b0, A2};
    tbl[10] = '{3'b101, 1'b1, 3'b111, 1'b0, 3'b000, 3'b100, 1'b1, 32'h0};
    tbl[11] = '{3'b110, 1'b1, 3'b111, 1'b0, 3'b000, 3'b000, 1'b0, 32'h0};
    tbl[12] = '{3'b110, 1'b1, 3'b111, 1'b1, 3'b010, 3'b000, 1'b0, A1};
    tbl[13] = '{3'b110, 1'b1, 3'b111, 1'b0, 3'b000, 3'b010, 1'b1, 32'h0};
    // Reset with stray downstream responses present: everything must stay quiet.
    clear();
    rst = 1'b1;
    m_rvalid = 1'b1;
    m_bvalid = 1'b1;
    tick();
    settle();
    chk("reset_ctl", ctl_outs(), 32'h0);
    chk("reset_rdata", 32'(s_rvalid), 32'h0);
    rst = 1'b0;
    tick();
    // Round-robin contention table: single-beat reads, responses always offered.
    m_rlast = 1'b1;
    for (int i = 0; i < 14; i++) begin
      s_arvalid = tbl[i].arv;
      m_arready = tbl[i].ardy;
      s_rready  = tbl[i].rrdy;
      settle();
      chk($sformatf("tbl%0d_marvalid", i), 32'(m_arvalid), 32'(tbl[i].e_mav));
      chk($sformatf("tbl%0d_sarready", i), 32'(s_arready), 32'(tbl[i].e_sar));
      chk($sformatf("tbl%0d_srvalid", i), 32'(s_rvalid), 32'(tbl[i].e_srv));
      chk($sformatf("tbl%0d_mrready", i), 32'(m_rready), 32'(tbl[i].e_mrr));
      if (tbl[i].e_mav) chk($sformatf("tbl%0d_araddr", i), m_araddr, tbl[i].e_addr);
      tick();
    end
    // Single 4-beat read by requester 1.
    do_reset();
    s_arlen = {4'd0, 4'd3, 4'd0};
    s_arvalid = 3'b010;
    m_arready = 1'b1;
    s_rready = 3'b111;
    settle();
    chk("rd1_arvalid_t0", 32'(m_arvalid), 32'h0);
    tick();
    settle();
    chk("rd1_arvalid_t1", 32'(m_arvalid), 32'h1);
    chk("rd1_araddr", m_araddr, A1);
    chk("rd1_arlen", 32'(m_arlen), 32'h3);
    chk("rd1_arready", 32'(s_arready), 32'h2);
    tick();
    s_arvalid = '0;
    for (int b = 0; b < 4; b++) begin
      m_rvalid = 1'b1;
      m_rid = 4'h5;
      m_rdata = 32'hA0 + 32'(b);
      m_rlast = (b == 3);
      settle();
      chk($sformatf("rd1_b%0d_rvalid", b), 32'(s_rvalid), 32'h2);
      chk($sformatf("rd1_b%0d_rdata", b), s_rdata[63:32], 32'hA0 + 32'(b));
      chk($sformatf("rd1_b%0d_rid", b), 32'(s_rid[7:4]), 32'h5);
      tick();
    end
    m_rlast = 1'b0;
    settle();
    chk("rd1_idle_rvalid", 32'(s_rvalid), 32'h0);
    chk("rd1_idle_rready", 32'(m_rready), 32'h0);
    m_rvalid = 1'b0;
    // Requester 2 writes with W leading AW and AW stalled downstream.
    do_reset();
    m_wready = 1'b1;
    s_bready = 3'b111;
    s_wvalid = 3'b100;
    s_wdata[95:64] = 32'hB0;
    settle();
    chk("wr_idle_wvalid", 32'(m_wvalid), 32'h0);
    tick();
    settle();
    chk("wr_b0_wvalid", 32'(m_wvalid), 32'h1);
    chk("wr_b0_wready", 32'(s_wready), 32'h4);
    chk("wr_b0_wdata", m_wdata, 32'hB0);
    tick();
    s_wdata[95:64] = 32'hB1;
    s_wlast = 3'b100;
    settle();
    chk("wr_b1_wlast", 32'(m_wlast), 32'h1);
    chk("wr_b1_wready", 32'(s_wready), 32'h4);
    tick();
    s_awvalid = 3'b100;
    s_awaddr[95:64] = 32'h2000_0040;
    settle();
    chk("wr_post_wvalid", 32'(m_wvalid), 32'h0);
    chk("wr_post_wready", 32'(s_wready), 32'h0);
    chk("wr_aw_valid", 32'(m_awvalid), 32'h1);
    chk("wr_aw_stall", 32'(s_awready), 32'h0);
    chk("wr_awaddr", m_awaddr, 32'h2000_0040);
    tick();
    m_bvalid = 1'b1;
    settle();
    chk("wr_stray_bvalid", 32'(s_bvalid), 32'h0);
    chk("wr_stray_bready", 32'(m_bready), 32'h0);
    tick();
    m_awready = 1'b1;
    settle();
    chk("wr_awready", 32'(s_awready), 32'h4);
    tick();
    s_awvalid = '0;
    s_wvalid = '0;
    m_awready = 1'b0;
    settle();
    chk("wr_bvalid", 32'(s_bvalid), 32'h4);
    chk("wr_bready", 32'(m_bready), 32'h1);
    chk("wr_awvalid_resp", 32'(m_awvalid), 32'h0);
    tick();
    settle();
    chk("wr_after_bvalid", 32'(s_bvalid), 32'h0);
    chk("wr_after_bready", 32'(m_bready), 32'h0);
    m_bvalid = 1'b0;
    // Concurrent: req0 reads 8 beats while req1 writes one beat.
    do_reset();
    s_arlen = {4'd0, 4'd0, 4'd7};
    s_arvalid = 3'b001;
    s_awvalid = 3'b010;
    s_wvalid = 3'b010;
    s_wlast = 3'b010;
    {m_arready, m_awready, m_wready} = 3'b111;
    s_rready = 3'b111;
    s_bready = 3'b111;
    tick();
    settle();
    chk("cc_arvalid", 32'(m_arvalid), 32'h1);
    chk("cc_awvalid", 32'(m_awvalid), 32'h1);
    chk("cc_wvalid", 32'(m_wvalid), 32'h1);
    chk("cc_arready", 32'(s_arready), 32'h1);
    chk("cc_awready", 32'(s_awready), 32'h2);
    tick();
    {s_arvalid, s_awvalid, s_wvalid} = '0;
    beats = 0;
    bcnt = 0;
    bad = 0;
    for (int j = 0; j < 30 && !(beats == 8 && bcnt == 1); j++) begin
      m_rvalid = 1'b1;
      m_rlast = (beats == 7);
      m_bvalid = (bcnt == 0);
      settle();
      if (s_rvalid[1] || s_rvalid[2] || s_bvalid[0] || s_bvalid[2]) bad++;
      if (s_rvalid[0] && m_rready) beats++;
      if (s_bvalid[1] && m_bready) bcnt++;
      tick();
    end
    {m_rvalid, m_rlast, m_bvalid} = '0;
    chk("cc_rbeats", 32'(beats), 32'd8);
    chk("cc_bcount", 32'(bcnt), 32'd1);
    chk("cc_misroute", 32'(bad), 32'd0);
    // Backpressure: s_rready[0] toggles through a 16-beat read.
    do_reset();
    s_arlen = {4'd0, 4'd0, 4'd15};
    s_arvalid = 3'b001;
    m_arready = 1'b1;
    tick();
    tick();
    s_arvalid = '0;
    beats = 0;
    mirr_err = 0;
    data_err = 0;
    for (int j = 0; j < 60 && beats < 16; j++) begin
      s_rready = {2'b00, (j % 2 == 0)};
      m_rvalid = 1'b1;
      m_rdata = 32'hD000 + 32'(beats);
      m_rlast = (beats == 15);
      settle();
      if (m_rready !== s_rready[0]) mirr_err++;
      if (s_rvalid[0] && m_rready) begin
        if (s_rdata[31:0] !== 32'hD000 + 32'(beats)) data_err++;
        beats++;
      end
      tick();
    end
    m_rlast = 1'b0;
    s_rready = 3'b001;
    settle();
    chk("bp_beats", 32'(beats), 32'd16);
    chk("bp_mirror", 32'(mirr_err), 32'd0);
    chk("bp_data", 32'(data_err), 32'd0);
    chk("bp_done_rvalid", 32'(s_rvalid), 32'h0);
    m_rvalid = 1'b0;
    // Reset mid-burst after req0 completed one read (pointer would otherwise favour req1).
    do_reset();
    s_arlen = {4'd0, 4'd3, 4'd0};
    s_arvalid = 3'b001;
    m_arready = 1'b1;
    s_rready = 3'b111;
    tick();
    tick();
    s_arvalid = '0;
    m_rvalid = 1'b1;
    m_rlast = 1'b1;
    tick();
    m_rvalid = 1'b0;
    m_rlast = 1'b0;
    s_arvalid = 3'b010;
    tick();
    tick();
    s_arvalid = '0;
    m_rvalid = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    s_arvalid = 3'b011;
    tick();
    settle();
    chk("rstmid_ctl", ctl_outs(), 32'h0);
    rst = 1'b0;
    tick();
    settle();
    chk("rstmid_ptr0_grant", 32'(s_arready), 32'h1);
    chk("rstmid_rready", 32'(m_rready), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
